// File: rtl/skinny_sbox8_pkg.sv
// Shared constants for the bit-sliced SKINNY-128 8-bit S-box: width, round count,
// and the inter-round bit permutation.
package skinny_sbox8_pkg;

    localparam int unsigned SboxWidth = 8;
    localparam int unsigned NumRounds = 4;

    // PermSrc[i] is the source bit of x that lands in output bit i after P.
    localparam logic [SboxWidth-1:0][2:0] PermSrc = {
        3'd2, 3'd1, 3'd7, 3'd6, 3'd4, 3'd0, 3'd3, 3'd5
    };

    typedef enum logic {
        ModePerm,
        ModeSwap
    } round_mode_e;

endpackage

// File: rtl/skinny_sbox8_lut.sv
// Golden table model of the SKINNY-128 8-bit S-box for verification use.
// The 256-entry table is filled from the plain round description.
module skinny_sbox8_lut (
    input  logic [7:0] si,
    output logic [7:0] so
);

    function automatic logic [7:0] s8_entry(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int r = 0; r < 4; r++) begin
            x[4] = x[4] ^ ~(x[7] | x[6]);
            x[0] = x[0] ^ ~(x[3] | x[2]);
            if (r < 3) begin
                x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
            end else begin
                x = {x[7:3], x[1], x[2], x[0]};
            end
        end
        return x;
    endfunction

    logic [7:0] table_q [256];

    for (genvar v = 0; v < 256; v++) begin : g_entry
        assign table_q[v] = s8_entry(8'(v));
    end

    assign so = table_q[si];

endmodule

// File: rtl/skinny_sbox8_round.sv
// One S-box round: two NOR/XOR updates, then either the full permutation P
// or (final round) a swap of bits 1 and 2.
module skinny_sbox8_round
    import skinny_sbox8_pkg::*;
(
    input  logic [SboxWidth-1:0] x_i,
    input  round_mode_e          mode_i,
    output logic [SboxWidth-1:0] x_o
);

    logic [SboxWidth-1:0] mixed;
    logic [SboxWidth-1:0] permuted;
    logic [SboxWidth-1:0] swapped;

    always_comb begin
        mixed    = x_i;
        mixed[4] = x_i[4] ^ ~(x_i[7] | x_i[6]);
        mixed[0] = x_i[0] ^ ~(x_i[3] | x_i[2]);
    end

    for (genvar i = 0; i < SboxWidth; i++) begin : g_perm
        assign permuted[i] = mixed[PermSrc[i]];
    end

    assign swapped = {mixed[7:3], mixed[1], mixed[2], mixed[0]};

    // mode_i is tied off per instance, so this mux reduces to wiring.
    always_comb begin
        x_o = permuted;
        if (mode_i == ModeSwap) begin
            x_o = swapped;
        end
    end

endmodule

// File: rtl/skinny_sbox8_hs.sv
// SKINNY-128 8-bit S-box: four chained bit-sliced rounds giving a zero-latency
// result, plus an enabled output register with asynchronous active-high reset.
module skinny_sbox8_hs
    import skinny_sbox8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [SboxWidth-1:0] si,
    output logic [SboxWidth-1:0] so,
    output logic [SboxWidth-1:0] so_r
);

    logic [NumRounds:0][SboxWidth-1:0] x;
    logic [SboxWidth-1:0]              so_r_q;

    assign x[0] = si;

    for (genvar r = 0; r < int'(NumRounds); r++) begin : g_round
        localparam round_mode_e Mode = (r == int'(NumRounds) - 1) ? ModeSwap : ModePerm;

        skinny_sbox8_round u_round (
            .x_i   (x[r]),
            .mode_i(Mode),
            .x_o   (x[r+1])
        );
    end

    assign so = x[NumRounds];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            so_r_q <= '0;
        end else if (en) begin
            so_r_q <= so;
        end
    end

    assign so_r = so_r_q;

endmodule

// File: tb/tb_skinny_sbox8_hs.sv
// Self-checking bench for skinny_sbox8_hs: exhaustive S-box sweep, spot values,
// register load/hold/priority/async reset, and a randomized register run.
module tb_skinny_sbox8_hs;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] si;
    logic [7:0] so;
    logic [7:0] so_r;
    logic [7:0] lut_so;

    int errors = 0;
    int checks = 0;

    skinny_sbox8_hs dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .si  (si),
        .so  (so),
        .so_r(so_r)
    );

    skinny_sbox8_lut u_lut (
        .si(si),
        .so(lut_so)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference S8 on an array of individual bits; nsrc[i] is the old bit that
    // becomes new bit i under P.
    function automatic logic [7:0] ref_s8(input logic [7:0] v);
        bit b[8];
        bit n[8];
        int nsrc[8] = '{5, 3, 0, 4, 6, 7, 1, 2};
        logic [7:0] res;
        for (int i = 0; i < 8; i++) b[i] = v[i];
        for (int r = 1; r <= 4; r++) begin
            b[4] = b[4] ^ !(b[7] || b[6]);
            b[0] = b[0] ^ !(b[3] || b[2]);
            if (r < 4) begin
                for (int i = 0; i < 8; i++) n[i] = b[nsrc[i]];
            end else begin
                n = b;
                n[1] = b[2];
                n[2] = b[1];
            end
            b = n;
        end
        for (int i = 0; i < 8; i++) res[i] = b[i];
        return res;
    endfunction

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (so_r !== 8'h00) begin
            errors++;
            $display("FAIL reset_so_r: got %02h expected 00", so_r);
        end
        checks++;
        if (so !== 8'h65) begin
            errors++;
            $display("FAIL reset_so_comb: got %02h expected 65", so);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exhaustive();
        int sweep_err = 0;
        en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            si = 8'(i);
            #1;
            checks++;
            if (so !== lut_so || so !== ref_s8(8'(i))) begin
                errors++;
                sweep_err++;
                $display("FAIL sweep si=%02h: got %02h lut %02h model %02h",
                         8'(i), so, lut_so, ref_s8(8'(i)));
            end
        end
        $display("exhaustive sweep of 256 inputs: %0d errors", sweep_err);
    endtask

    task automatic test_spot();
        logic [7:0] ins  [4] = '{8'h00, 8'h01, 8'h02, 8'hFF};
        logic [7:0] outs [4] = '{8'h65, 8'h4C, 8'h6A, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            si = ins[i];
            #1;
            checks++;
            if (so !== outs[i]) begin
                errors++;
                $display("FAIL spot si=%02h: got %02h expected %02h", ins[i], so, outs[i]);
            end
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (so_r !== 8'h00) begin
            errors++;
            $display("FAIL reg_rst_pulse: got %02h expected 00", so_r);
        end
        rst = 1'b0;
        en  = 1'b1;
        si  = 8'h01;
        @(negedge clk);
        checks++;
        if (so_r !== 8'h4C) begin
            errors++;
            $display("FAIL reg_load: got %02h expected 4c", so_r);
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        si = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (so_r !== 8'h4C) begin
            errors++;
            $display("FAIL hold_so_r: got %02h expected 4c", so_r);
        end
        checks++;
        if (so !== 8'h65) begin
            errors++;
            $display("FAIL hold_so: got %02h expected 65", so);
        end
    endtask

    task automatic test_priority();
        rst = 1'b1;
        en  = 1'b1;
        si  = 8'hFF;
        @(negedge clk);
        checks++;
        if (so_r !== 8'h00) begin
            errors++;
            $display("FAIL priority_rst_wins: got %02h expected 00", so_r);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (so_r !== 8'hFF) begin
            errors++;
            $display("FAIL priority_release: got %02h expected ff", so_r);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (so_r !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %02h expected 00", so_r);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp_q = 8'h00;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            si  = 8'($urandom);
            en  = 1'($urandom);
            rst = ($urandom_range(0, 19) == 0);
            #1;
            if (rst) exp_q = 8'h00;
            checks++;
            if (so !== ref_s8(si)) begin
                errors++;
                $display("FAIL rand_so si=%02h: got %02h expected %02h", si, so, ref_s8(si));
            end
            @(posedge clk);
            if (rst) exp_q = 8'h00;
            else if (en) exp_q = ref_s8(si);
            #1;
            checks++;
            if (so_r !== exp_q) begin
                errors++;
                $display("FAIL rand_so_r cycle %0d: got %02h expected %02h", c, so_r, exp_q);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        si  = 8'h00;
        test_reset();
        test_exhaustive();
        test_spot();
        test_register();
        test_hold();
        test_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skinny_sbox8_hs.md
SKINNY_SBOX8_HS -- requirements
Module: skinny_sbox8_hs

Interface
REQ-001 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for the output register.
REQ-003 rst  input  1  asynchronous active-high reset; clears the output register.
REQ-004 so  output  8  combinational S-box result, so = S8(si).
REQ-005 si  input  8  S-box input byte, bit 7 = MSB.
REQ-006 en  input  1  load enable for so_r.
REQ-007 so_r  output  8  registered copy of so.
REQ-008 The block SHALL have no parameters.

Function
REQ-009 so SHALL equal the SKINNY-128 8-bit S-box S8(si) for all 256 inputs, bit-exact with the table model skinny_sbox8_lut.
REQ-010 so SHALL depend only on si, with zero latency, and SHALL be independent of clk, rst and en.
REQ-011 S8 SHALL be computed bit-sliced as four rounds on x = si (bits x7..x0), with no lookup table.
REQ-012 Rounds 1-3: x4 ^= NOR(x7,x6); x0 ^= NOR(x3,x2); then apply permutation P.
REQ-013 P SHALL map (x7,x6,x5,x4,x3,x2,x1,x0) to (x2,x1,x7,x6,x4,x0,x3,x5).
REQ-014 Round 4: apply the same NOR/XOR step, then swap only bits x1 and x2 (no P); the result SHALL drive so.
REQ-015 The datapath SHALL use only NOR/XOR (or equivalent 2-input gates) and wiring, with no case tables or ROMs.
REQ-016 On a rising clk edge with en=1 and rst=0, so_r SHALL load so, giving one-cycle latency from si to so_r.
REQ-017 With en=0, so_r SHALL hold its value.
REQ-018 A change of si between edges SHALL affect only so, not so_r.
REQ-019 If en=1 and rst=1 together, reset SHALL win.

Reset
REQ-020 Asserting rst SHALL clear so_r to 8'h00 immediately, without waiting for a clock edge.
REQ-021 so SHALL not be affected by rst.
REQ-022 After rst deasserts, the first rising edge with en=1 SHALL load so = S8(si).
REQ-023 Reset asserted mid-operation SHALL discard the held value; no state other than so_r exists.

Structure
REQ-024 A shared package SHALL hold the permutation P (index constants), the round count 4, and the width 8.
REQ-025 One sub-module skinny_sbox8_round SHALL implement one NOR/XOR step plus P, with a mode input selecting P or the final x1/x2 swap.
REQ-026 skinny_sbox8_hs SHALL instantiate skinny_sbox8_round four times, chained, plus the so_r register.
REQ-027 skinny_sbox8_lut (256-entry combinational table, ports so, si) SHALL exist as the golden model for verification only.

Verification
REQ-028 Exhaustive: sweep si = 0x00..0xFF with 1 time-unit settle each -> so equals the skinny_sbox8_lut output every time; print a pass/fail summary.
REQ-029 Spot values: si=0x00 -> so=0x65; si=0x01 -> so=0x4C; si=0x02 -> so=0x6A; si=0xFF -> so=0xFF.
REQ-030 Register: rst pulse -> so_r=0x00 at once, with no clock; then en=1, si=0x01, one edge -> so_r=0x4C.
REQ-031 Hold: en=0, si changed to 0x00, two edges -> so_r stays 0x4C while so=0x65.
REQ-032 Priority: rst=1 and en=1 with si=0xFF across an edge -> so_r=0x00; release rst, one edge -> so_r=0xFF.
REQ-033 Async reset: assert rst between clock edges while so_r=0xFF -> so_r=0x00 before the next edge.
